// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into a registered req/gnt/rvalid bus access.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses finish with err_o and no bus access.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  data_src_i,
  input  logic [1:0]  store_size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        load_valid_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        is_load, ld_sign;
  logic [1:0]  ld_size, off;

  logic        req, st, sgn, mis, timeout;
  logic [1:0]  sz, eoff;
  logic [3:0]  be;
  logic [31:0] wd, sh, ext;

  // Request decode; sz: 0 byte, 1 half, 2 word. A store wins over a load.
  always_comb begin
    req  = mem_read_i | mem_write_i;
    st   = mem_write_i;
    sgn  = 1'b0;
    sz   = 2'd2;
    eoff = 2'd0;
    be   = 4'b1111;
    wd   = wdata_i;
    if (st) begin
      sz = (store_size_i == 2'b11) ? 2'd2 : store_size_i;
    end else begin
      case (data_src_i)
        3'b000:  begin sz = 2'd0; sgn = 1'b1; end
        3'b001:  begin sz = 2'd1; sgn = 1'b1; end
        3'b100:  sz = 2'd0;
        3'b101:  sz = 2'd1;
        default: sz = 2'd2;
      endcase
    end
    case (sz)
      2'd0: begin
        eoff = addr_i[1:0];
        be   = 4'b0001 << addr_i[1:0];
        wd   = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        eoff = {addr_i[1], 1'b0};
        be   = 4'b0011 << {addr_i[1], 1'b0};
        wd   = {2{wdata_i[15:0]}};
      end
      default: begin
        eoff = 2'd0;
        be   = 4'b1111;
        wd   = wdata_i;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((sz == 2'd1) && addr_i[0]) || ((sz == 2'd2) && (addr_i[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  always_comb begin
    sh = bus_rdata_i >> {off, 3'b000};
    case (ld_size)
      2'd0:    ext = ld_sign ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      2'd1:    ext = ld_sign ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  assign timeout      = (cnt == TO_LAST);
  assign stall_o      = (state == IDLE) ? req : (state != DONE);
  assign load_valid_o = (state == DONE) && is_load && !err_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_load     <= 1'b0;
      ld_sign     <= 1'b0;
      ld_size     <= '0;
      off         <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          bus_we_o    <= st;
          bus_addr_o  <= {addr_i[31:2], 2'b00};
          bus_be_o    <= be;
          bus_wdata_o <= wd;
          is_load     <= !st;
          ld_size     <= sz;
          ld_sign     <= sgn;
          off         <= eoff;
          cnt         <= '0;
          rdata_o     <= '0;
          if (mis) begin
            err_o <= 1'b1;
            state <= DONE;
          end else begin
            err_o     <= 1'b0;
            bus_req_o <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // A grant on the last allowed cycle still aborts: WAIT would overrun the budget.
          if (timeout) begin
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
            rdata_o   <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
            if (bus_gnt_i) begin
              bus_req_o <= 1'b0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            if (is_load) rdata_o <= ext;
            state <= DONE;
          end else if (timeout) begin
            err_o   <= 1'b1;
            rdata_o <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit plus reset/timeout/stale-response sequences.
module tb_load_store_unit;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  ds;
    logic [1:0]  ss;
    logic [31:0] a, wd, brd;
    int          gd, rdl;
    int          e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rdata;
    logic        e_lv, e_err;
    int          e_st;
  } vec_t;

  typedef struct {
    int          stalls, reqs;
    logic        fin, unstable, we, lv, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  data_src = '0;
  logic [1:0]  store_size = '0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic        stall, load_valid, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        rd4 = 1'b0, gnt4 = 1'b0, rv4 = 1'b0;
  logic        stall4, lv4, err4, bus_req4, bus_we4;
  logic [31:0] rdata4, bus_addr4, bus_wdata4;
  logic [3:0]  bus_be4;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .data_src_i(data_src),
    .store_size_i(store_size), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .rdata_o(rdata), .load_valid_o(load_valid), .err_o(err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(rd4), .mem_write_i(1'b0), .data_src_i(data_src),
    .store_size_i(store_size), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall4), .rdata_o(rdata4), .load_valid_o(lv4), .err_o(err4),
    .bus_req_o(bus_req4), .bus_we_o(bus_we4), .bus_addr_o(bus_addr4), .bus_be_o(bus_be4),
    .bus_wdata_o(bus_wdata4), .bus_gnt_i(gnt4), .bus_rvalid_i(rv4),
    .bus_rdata_i(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, output res_t r);
    int reqc = 0, waitc = 0;
    bit granted = 1'b0;
    r = '{default: '0};
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; data_src = v.ds; store_size = v.ss;
    addr = v.a; wdata = v.wd; bus_rdata = v.brd; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall) begin
        r.fin = 1'b1; r.rdata = rdata; r.lv = load_valid; r.err = err;
        break;
      end
      r.stalls++;
      if (bus_req) begin
        if (reqc == 0) begin
          r.addr = bus_addr; r.be = bus_be; r.we = bus_we; r.wdata = bus_wdata;
        end else if ({r.addr, r.be, r.we, r.wdata} !== {bus_addr, bus_be, bus_we, bus_wdata}) begin
          r.unstable = 1'b1;
        end
        reqc++;
      end else if (granted) begin
        waitc++;
      end
      bus_gnt    = bus_req && (reqc == v.gd + 1);
      bus_rvalid = granted && (waitc == v.rdl + 1);
      if (bus_gnt) granted = 1'b1;
      @(negedge clk);
    end
    r.reqs = reqc;
    mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    res_t r;
    int   reqc;
    bit   fin;

    vt[0]  = '{1'b1,1'b0,3'b100,2'b00,32'h103,32'h0,32'h80FF1234,0,0, 1,1'b0,32'h100,4'b1000,32'h0,32'h00000080,1'b1,1'b0,3};
    vt[1]  = '{1'b1,1'b0,3'b001,2'b00,32'h102,32'h0,32'h80010000,0,0, 1,1'b0,32'h100,4'b1100,32'h0,32'hFFFF8001,1'b1,1'b0,3};
    vt[2]  = '{1'b1,1'b0,3'b010,2'b00,32'h100,32'h0,32'hDEADBEEF,0,0, 1,1'b0,32'h100,4'b1111,32'h0,32'hDEADBEEF,1'b1,1'b0,3};
    vt[3]  = '{1'b0,1'b1,3'b000,2'b00,32'h201,32'hAB,32'hFFFFFFFF,0,0, 1,1'b1,32'h200,4'b0010,32'hABABABAB,32'h0,1'b0,1'b0,3};
    vt[4]  = '{1'b1,1'b0,3'b000,2'b00,32'h001,32'h0,32'h00008000,0,0, 1,1'b0,32'h000,4'b0010,32'h0,32'hFFFFFF80,1'b1,1'b0,3};
    vt[5]  = '{1'b1,1'b0,3'b101,2'b00,32'h002,32'h0,32'hF00DBEEF,0,0, 1,1'b0,32'h000,4'b1100,32'h0,32'h0000F00D,1'b1,1'b0,3};
    vt[6]  = '{1'b0,1'b1,3'b000,2'b01,32'h302,32'h1234CDEF,32'h0,0,0, 1,1'b1,32'h300,4'b1100,32'hCDEFCDEF,32'h0,1'b0,1'b0,3};
    vt[7]  = '{1'b0,1'b1,3'b000,2'b11,32'h404,32'h11223344,32'h0,0,0, 1,1'b1,32'h404,4'b1111,32'h11223344,32'h0,1'b0,1'b0,3};
    vt[8]  = '{1'b1,1'b1,3'b010,2'b00,32'h503,32'h5A,32'h77777777,0,0, 1,1'b1,32'h500,4'b1000,32'h5A5A5A5A,32'h0,1'b0,1'b0,3};
    vt[9]  = '{1'b1,1'b0,3'b010,2'b00,32'h600,32'h0,32'hCAFEF00D,2,2, 3,1'b0,32'h600,4'b1111,32'h0,32'hCAFEF00D,1'b1,1'b0,7};
    vt[10] = '{1'b1,1'b0,3'b011,2'b00,32'h700,32'h0,32'h12345678,0,0, 1,1'b0,32'h700,4'b1111,32'h0,32'h12345678,1'b1,1'b0,3};
    vt[11] = '{1'b1,1'b0,3'b000,2'b00,32'h3FF,32'h0,32'h7F000000,0,0, 1,1'b0,32'h3FC,4'b1000,32'h0,32'h0000007F,1'b1,1'b0,3};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[12] = '{1'b1,1'b0,3'b010,2'b00,32'h102,32'h0,32'hA5A55A5A,0,0, 0,1'b0,32'h0,4'b0,32'h0,32'h0,1'b0,1'b1,1};
    vt[13] = '{1'b1,1'b0,3'b001,2'b00,32'h103,32'h0,32'h7FFF0000,0,0, 0,1'b0,32'h0,4'b0,32'h0,32'h0,1'b0,1'b1,1};
`else
    vt[12] = '{1'b1,1'b0,3'b010,2'b00,32'h102,32'h0,32'hA5A55A5A,0,0, 1,1'b0,32'h100,4'b1111,32'h0,32'hA5A55A5A,1'b1,1'b0,3};
    vt[13] = '{1'b1,1'b0,3'b001,2'b00,32'h103,32'h0,32'h7FFF0000,0,0, 1,1'b0,32'h100,4'b1100,32'h0,32'h00007FFF,1'b1,1'b0,3};
`endif

    // Reset state
    #12;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_req_we_lv_err", {28'b0, bus_req, bus_we, load_valid, err}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", {28'b0, bus_be}, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run(vt[i], r);
      chk($sformatf("v%0d_fin", i), {31'b0, r.fin}, 32'h1);
      chk($sformatf("v%0d_stalls", i), r.stalls, vt[i].e_st);
      chk($sformatf("v%0d_reqs", i), r.reqs, vt[i].e_req);
      chk($sformatf("v%0d_rdata", i), r.rdata, vt[i].e_rdata);
      chk($sformatf("v%0d_lv", i), {31'b0, r.lv}, {31'b0, vt[i].e_lv});
      chk($sformatf("v%0d_err", i), {31'b0, r.err}, {31'b0, vt[i].e_err});
      chk($sformatf("v%0d_stable", i), {31'b0, r.unstable}, 32'h0);
      if (vt[i].e_req > 0) begin
        chk($sformatf("v%0d_addr", i), r.addr, vt[i].e_addr);
        chk($sformatf("v%0d_be", i), {28'b0, r.be}, {28'b0, vt[i].e_be});
        chk($sformatf("v%0d_we", i), {31'b0, r.we}, {31'b0, vt[i].e_we});
        if (vt[i].e_we) chk($sformatf("v%0d_wdata", i), r.wdata, vt[i].e_wd);
      end
    end

    // Reset during REQ drops bus_req_o at once
    @(negedge clk); mem_read = 1'b1; data_src = 3'b010; addr = 32'h900;
    @(negedge clk); #1;
    chk("rreq_req_before", {31'b0, bus_req}, 32'h1);
    mem_read = 1'b0; rst_n = 1'b0; #1;
    chk("rreq_req_after", {31'b0, bus_req}, 32'h0);
    chk("rreq_stall_after", {31'b0, stall}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Reset during WAIT, then a stale response in IDLE
    @(negedge clk); mem_read = 1'b1; addr = 32'h904; bus_rdata = 32'h13572468;
    @(negedge clk); bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; #1;
    chk("rwait_in_wait", {30'b0, bus_req, stall}, 32'h1);
    mem_read = 1'b0; rst_n = 1'b0; #1;
    chk("rwait_idle", {30'b0, bus_req, stall}, 32'h0);
    @(negedge clk); rst_n = 1'b1; bus_rvalid = 1'b1;
    @(negedge clk); bus_rvalid = 1'b0; #1;
    chk("stale_lv", {30'b0, load_valid, stall}, 32'h0);
    chk("stale_rdata", rdata, 32'h0);

    // Timeout with TIMEOUT_CYCLES = 4 and no grant
    @(negedge clk); data_src = 3'b010; addr = 32'h800; rd4 = 1'b1;
    reqc = 0; fin = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk); #1;
      if (bus_req4) reqc++;
      if (!stall4) fin = 1'b1;
    end
    rd4 = 1'b0;
    chk("to_fin", {31'b0, fin}, 32'h1);
    chk("to_req_cycles", reqc, 4);
    chk("to_err", {31'b0, err4}, 32'h1);
    chk("to_req_lv", {30'b0, bus_req4, lv4}, 32'h0);
    chk("to_rdata", rdata4, 32'h0);

    // Late response after the timeout is ignored
    @(negedge clk); rv4 = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); rv4 = 1'b0; #1;
    chk("late_idle", {30'b0, stall4, lv4}, 32'h0);
    chk("late_rdata", rdata4, 32'h0);

    // Short-timeout unit still completes a zero-wait access afterwards
    @(negedge clk); rd4 = 1'b1; addr = 32'h804; bus_rdata = 32'h0BADF00D;
    @(negedge clk); #1;
    chk("t4_req", {31'b0, bus_req4}, 32'h1);
    gnt4 = 1'b1;
    @(negedge clk); gnt4 = 1'b0; rv4 = 1'b1;
    @(negedge clk); rv4 = 1'b0; #1;
    rd4 = 1'b0;
    chk("t4_done", {29'b0, stall4, lv4, err4}, 32'h2);
    chk("t4_rdata", rdata4, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
